// File: rtl/remote_comm.sv
// Remote command link: sends 3-byte 8N1 command frames on TX and receives
// single response bytes on RX, both running from one BAUD_DIV bit-time.
module remote_comm #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        clr_resp_rdy,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        cmd_sent,
    output logic [7:0]  resp,
    output logic        resp_rdy
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned BIT_W = 4;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] STOP_IDX  = BIT_W'(9);

    typedef enum logic [1:0] {
        IDLE,
        SEND_CMD,
        SEND_HI,
        SEND_LO
    } tx_state_e;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT
    } rx_state_e;

    // ---------------- transmitter ----------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0] tx_bit_q, tx_bit_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [15:0]      data_q, data_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             cmd_sent_q, cmd_sent_d;

    logic [7:0]       cur_byte_c;
    logic [9:0]       frame_c;
    logic [BIT_W-1:0] tx_bit_inc_c;
    logic             accept_c;

    assign accept_c     = snd_cmd && (tx_state_q == IDLE);
    assign tx_bit_inc_c = tx_bit_q + BIT_W'(1);
    assign frame_c      = {1'b1, cur_byte_c, 1'b0};

    always_comb begin
        cur_byte_c = data_q[7:0];
        case (tx_state_q)
            SEND_CMD: cur_byte_c = cmd_q;
            SEND_HI:  cur_byte_c = data_q[15:8];
            default:  cur_byte_c = data_q[7:0];
        endcase
    end

    // Bit sequencer: each SEND state emits one 10-bit frame, next frame starts immediately
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        cmd_sent_d = 1'b0;

        if (tx_state_q == IDLE) begin
            tx_d = 1'b1;
            if (snd_cmd) begin
                cmd_d      = cmd;
                data_d     = data;
                tx_state_d = SEND_CMD;
                busy_d     = 1'b1;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = 1'b0;
            end
        end else if (tx_cnt_q != BIT_LAST) begin
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end else begin
            tx_cnt_d = '0;
            if (tx_bit_q != STOP_IDX) begin
                tx_bit_d = tx_bit_inc_c;
                tx_d     = frame_c[tx_bit_inc_c];
            end else begin
                tx_bit_d = '0;
                tx_d     = 1'b0;
                case (tx_state_q)
                    SEND_CMD: tx_state_d = SEND_HI;
                    SEND_HI:  tx_state_d = SEND_LO;
                    default: begin
                        tx_state_d = IDLE;
                        tx_d       = 1'b1;
                        busy_d     = 1'b0;
                        cmd_sent_d = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            cmd_sent_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            cmd_sent_q <= cmd_sent_d;
        end
    end

    // ---------------- receiver ----------------
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [7:0]       resp_q, resp_d;
    logic             resp_rdy_q, resp_rdy_d;

    // Synchronizer plus one history flop for start-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // Clear is applied first so a byte completing in the same cycle wins
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        resp_d     = resp_q;
        resp_rdy_d = resp_rdy_q;

        if (clr_resp_rdy || accept_c) begin
            resp_rdy_d = 1'b0;
        end

        case (rx_state_q)
            R_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = R_START;
                    rx_cnt_d   = '0;
                end
            end
            R_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = R_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            R_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        resp_d     = rx_sh_q;
                        resp_rdy_d = 1'b1;
                        rx_state_d = R_IDLE;
                    end else begin
                        rx_state_d = R_WAIT;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            R_WAIT: begin
                if (rx_s2_q) begin
                    rx_state_d = R_IDLE;
                end
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            resp_q     <= '0;
            resp_rdy_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            resp_q     <= resp_d;
            resp_rdy_q <= resp_rdy_d;
        end
    end

    assign TX       = tx_q;
    assign busy     = busy_q;
    assign cmd_sent = cmd_sent_q;
    assign resp     = resp_q;
    assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at BAUD_DIV=16: TX bytes and RX responses are
// checked against scoreboard queues filled when stimulus is driven.
module tb_remote_comm;

    localparam int unsigned BD = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_resp_rdy;
    logic        RX;
    logic        TX;
    logic        busy;
    logic        cmd_sent;
    logic [7:0]  resp;
    logic        resp_rdy;

    int n_cmp = 0;
    int n_err = 0;
    int sent_pulses = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .snd_cmd      (snd_cmd),
        .cmd          (cmd),
        .data         (data),
        .clr_resp_rdy (clr_resp_rdy),
        .RX           (RX),
        .TX           (TX),
        .busy         (busy),
        .cmd_sent     (cmd_sent),
        .resp         (resp),
        .resp_rdy     (resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (cmd_sent === 1'b1) sent_pulses++;

    // Waits n falling clock edges, giving up early if reset is asserted
    task automatic wait_clk(input int n, inout bit ab);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!rst_n) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    // TX decoder: samples mid-bit and pops the expected byte per completed frame
    initial begin
        bit         ab;
        logic       start_b;
        logic       stop_b;
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge TX);
            ab = 1'b0;
            b  = '0;
            wait_clk(BD / 2, ab);
            start_b = TX;
            for (int i = 0; i < 8; i++) begin
                if (!ab) begin
                    wait_clk(BD, ab);
                    b[i] = TX;
                end
            end
            if (!ab) wait_clk(BD, ab);
            stop_b = TX;
            if (!ab) begin
                check("tx_start_bit", 32'(start_b), 32'd0);
                check("tx_stop_bit", 32'(stop_b), 32'd1);
                check("tx_expected_pending", (exp_tx.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_tx.size() > 0) begin
                    e = exp_tx.pop_front();
                    check("tx_byte", 32'(b), 32'(e));
                end
            end
        end
    end

    // RX scoreboard: every rising resp_rdy must match the next expected byte
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge resp_rdy);
            @(negedge clk);
            check("rx_expected_pending", (exp_rx.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_rx.size() > 0) begin
                e = exp_rx.pop_front();
                check("rx_byte", 32'(resp), 32'(e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic xfer(input logic [7:0] c, input logic [15:0] d, input bit second,
                        output logic rdy0);
        int n;
        bit busy_ok;
        int sent0;
        exp_tx.push_back(c);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
        sent0 = sent_pulses;
        @(negedge clk);
        cmd = c; data = d; snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0; cmd = '0; data = '0;
        rdy0 = resp_rdy;
        n = 0;
        busy_ok = 1'b1;
        while (cmd_sent !== 1'b1 && n < 600) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (second && n == 100) begin
                cmd = 8'hFF; data = 16'h1111; snd_cmd = 1'b1;
            end else begin
                snd_cmd = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        snd_cmd = 1'b0;
        check("xfer_latency_in_range", (n >= 479 && n <= 481) ? 32'd1 : 32'd0, 32'd1);
        check("xfer_busy_throughout", 32'(busy_ok), 32'd1);
        check("xfer_busy_low_at_sent", 32'(busy), 32'd0);
        @(negedge clk);
        check("xfer_cmd_sent_one_cycle", 32'(cmd_sent), 32'd0);
        repeat (20) @(negedge clk);
        check("xfer_cmd_sent_count", 32'(sent_pulses - sent0), 32'd1);
        check("xfer_tx_queue_drained", 32'(exp_tx.size()), 32'd0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        if (stop) exp_rx.push_back(b);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BD) @(negedge clk);
        end
        RX = stop;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    initial begin
        logic rdy0;
        int   sent0;
        rst_n = 1'b0; snd_cmd = 1'b0; cmd = '0; data = '0;
        clr_resp_rdy = 1'b0; RX = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(TX), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_sent", 32'(cmd_sent), 32'd0);
        check("rst_resp_rdy", 32'(resp_rdy), 32'd0);
        check("rst_resp", 32'(resp), 32'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        xfer(8'h05, 16'hABCD, 1'b0, rdy0);

        rx_frame(8'hA5, 1'b1);
        check("rx_a5_rdy", 32'(resp_rdy), 32'd1);
        check("rx_a5_resp", 32'(resp), 32'hA5);
        clr_resp_rdy = 1'b1;
        @(negedge clk);
        clr_resp_rdy = 1'b0;
        check("clr_rdy", 32'(resp_rdy), 32'd0);
        check("clr_resp_kept", 32'(resp), 32'hA5);

        rx_frame(8'h3C, 1'b0);
        check("frame_err_rdy", 32'(resp_rdy), 32'd0);
        check("frame_err_resp", 32'(resp), 32'hA5);
        rx_frame(8'h7E, 1'b1);
        check("rx_7e_rdy", 32'(resp_rdy), 32'd1);
        check("rx_7e_resp", 32'(resp), 32'h7E);

        xfer(8'h05, 16'hABCD, 1'b1, rdy0);
        check("snd_cmd_clears_rdy", 32'(rdy0), 32'd0);

        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_rdy", 32'(resp_rdy), 32'd0);
        check("glitch_resp_kept", 32'(resp), 32'h7E);

        exp_tx.push_back(8'h5A);
        sent0 = sent_pulses;
        @(negedge clk);
        cmd = 8'h5A; data = 16'h1234; snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
        repeat (240) @(negedge clk);
        check("mid_hi_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(TX), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_cmd_sent", 32'(cmd_sent), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_sent", 32'(sent_pulses - sent0), 32'd0);
        check("mid_rst_cmd_byte_seen", 32'(exp_tx.size()), 32'd0);

        xfer(8'hC3, 16'h0F1E, 1'b0, rdy0);

        check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
